flash_burst_read_streamer: RTL and testbench
============================================

// Module: flash_burst_read_streamer
// PURPOSE
//  Parametrised successor to the single-word flash read controller. Takes one start command and
//  fetches NUM_BURSTS consecutive Avalon-MM bursts of BURST_LEN words from flash into an internal FIFO.
//  Audio and playback logic drains the FIFO through a valid/ready stream, so the sample path never
//  handshakes per word. Sits between the flash controller IP and the music-player sample sequencer.
// PARAMETERS
//  ADDR_W       23   flash word-address width
//  DATA_W       32   flash data width = stream width
//  BURST_LEN    8    words per burst; must be in 1..FIFO_DEPTH and fit in BURST_W bits
//  BURST_W      7    flash_mem_burstcount width
//  FIFO_DEPTH   16   FIFO entries, power of 2, >= BURST_LEN
//  NBURST_W     16   width of num_bursts
//  TIMEOUT_CYC  200  max stall cycles in REQ/RECV before error (only with FLASH_RD_TIMEOUT_EN)
// PORTS
//  clk                     in   1         system clock
//  RST                     in   1         asynchronous, active-high reset
//  flash_mem_read          out  1         Avalon read request
//  flash_mem_address       out  ADDR_W    burst start word address
//  flash_mem_burstcount    out  BURST_W   always BURST_LEN while read is high, else 0
//  flash_mem_waitrequest   in   1         slave stall; command is held while high
//  flash_mem_readdata      in   DATA_W    returned beat data
//  flash_mem_readdatavalid in   1         returned beat qualifier
//  start                   in   1         one-cycle command; sampled only in IDLE
//  start_addr              in   ADDR_W    first word address
//  num_bursts              in   NBURST_W  number of bursts to fetch; 0 = command ignored
//  busy                    out  1         high from accepted start until last beat stored or error
//  error                   out  1         sticky timeout flag; cleared only by RST
//  out_data                out  DATA_W    FIFO head (show-ahead)
//  out_valid               out  1         FIFO not empty
//  out_ready               in   1         consumer pop; pop = out_valid & out_ready
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; FIFO empty; counters 0. RST mid-burst discards FIFO and in-flight beats.
//  FSM, all outputs registered:
//   IDLE: start & !error & num_bursts!=0 -> latch addr and remaining=num_bursts, busy<=1, go WAIT_ROOM.
//         Start is ignored otherwise, including while busy.
//   WAIT_ROOM: if fifo_free >= BURST_LEN, drive read=1, address=addr, burstcount=BURST_LEN, go REQ.
//   REQ: hold all command signals while waitrequest=1.
//        On the cycle with waitrequest=0 the command is accepted; next cycle read=0 and go RECV.
//   RECV: each readdatavalid pushes readdata and increments beat_cnt.
//         On beat BURST_LEN: remaining-=1.
//         If remaining is now 0 -> busy<=0, go IDLE.
//         Otherwise addr+=BURST_LEN (wraps modulo 2^ADDR_W) and go WAIT_ROOM.
//  Latency: with the FIFO empty and waitrequest=0, start at cycle N gives read=1 at N+1.
//   The beat stored at cycle M appears at out_data/out_valid at M+1.
//  Flow control: readdatavalid cannot be back-pressured, so room for a whole burst is reserved
//   before each request. The FIFO therefore never overflows. Beats arriving outside RECV are dropped.
//  FIFO: push and pop in the same cycle are both honoured at any level, including full and empty.
//   A pop on empty is a no-op. fifo_free = FIFO_DEPTH - count.
//  Stream: the FIFO keeps draining after busy falls. out_data is stable while out_valid & !out_ready.
// CONFIGURATION
//  FLASH_RD_TIMEOUT_EN defined:
//   - A 16-bit stall counter runs in REQ and RECV. It clears on command accept, on every beat,
//     and in IDLE/WAIT_ROOM.
//   - When the counter exceeds TIMEOUT_CYC: error<=1, read<=0, busy<=0, go IDLE.
//     FIFO contents are kept; further start commands are ignored until RST.
//  FLASH_RD_TIMEOUT_EN undefined: no counter; error is tied 0; the FSM waits indefinitely.
// STRUCTURE
//  Package flash_rd_pkg: state enum {IDLE, WAIT_ROOM, REQ, RECV}, BURST_W default, TIMEOUT default.
//  Sub-module flash_rd_fifo: parametrised show-ahead sync FIFO (DATA_W, FIFO_DEPTH).
//   Outputs count, empty, full; async RST.
//  Top level holds the FSM, address/remaining/beat counters and the optional watchdog.
// TESTING
//  1. Reset: RST pulse mid-RECV -> read=0, busy=0, out_valid=0 next edge; new start then works.
//  2. Basic: start_addr=0x100, num_bursts=2, out_ready=1, no wait
//     -> requests at 0x100 then 0x108, burstcount=8; 16 words out in order; busy falls after beat 16.
//  3. Backpressure: out_ready=0, num_bursts=3, FIFO_DEPTH=16
//     -> 2 bursts issued, 3rd held in WAIT_ROOM until >=8 pops; no data lost.
//  4. waitrequest high 5 cycles -> read/address/burstcount stable for 6 cycles; exactly one command accepted.
//  5. Wrap: start_addr=0x7FFFF8, num_bursts=2 -> second burst address 0x000000.
//  6. Timeout (EN defined): no readdatavalid -> error=1 after TIMEOUT_CYC+1 stall cycles;
//     start ignored until RST. EN undefined: error stays 0.
//  Also: start while busy ignored; num_bursts=0 leaves busy=0.

Source files
------------

// File: rtl/flash_rd_pkg.sv
// Shared definitions for the flash burst read streamer.
//   rd_state_t       : sequencer states (IDLE, WAIT_ROOM, REQ, RECV)
//   BURST_W_DEFAULT  : default width of the Avalon burstcount field
//   TIMEOUT_DEFAULT  : default stall limit for the optional watchdog
package flash_rd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ROOM,
        REQ,
        RECV
    } rd_state_t;

    localparam int BURST_W_DEFAULT = 7;
    localparam int TIMEOUT_DEFAULT = 200;

endpackage

// File: rtl/flash_rd_fifo.sv
// Show-ahead synchronous FIFO used as the sample buffer of the burst streamer.
// The head entry is visible on head whenever empty is low; a pop advances it.
// Push and pop in the same cycle are both honoured at any fill level; a pop
// while empty is ignored. Storage is not reset, only pointers and count.
// Ports:
//   clk, RST       clock, asynchronous active-high reset
//   push/push_data write request and data
//   pop            advance the head
//   head           current head entry (valid when !empty)
//   count          number of stored entries (0..FIFO_DEPTH)
//   empty, full    level flags
module flash_rd_fifo
    import flash_rd_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 16,
    localparam int PTR_W     = $clog2(FIFO_DEPTH),
    localparam int CNT_W     = PTR_W + 1
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full
);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign do_pop  = pop && !empty;
    // When full, a simultaneous pop frees the slot the push writes into.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/flash_burst_read_streamer.sv
// Fetches num_bursts consecutive Avalon-MM bursts of BURST_LEN words from
// flash into a show-ahead FIFO and presents them as a valid/ready stream.
// Room for a whole burst is reserved before every request because
// readdatavalid cannot be stalled.
// Optional build macro: FLASH_RD_TIMEOUT_EN enables a stall watchdog that
// aborts the transfer and sets a sticky error flag; without it error is 0.
// Ports:
//   clk, RST                 clock, asynchronous active-high reset
//   flash_mem_*              Avalon-MM burst read master
//   start/start_addr/num_bursts  one-cycle command, sampled in IDLE only
//   busy                     transfer in progress
//   error                    sticky watchdog timeout flag
//   out_data/out_valid/out_ready  sample stream (pop = out_valid & out_ready)
module flash_burst_read_streamer
    import flash_rd_pkg::*;
#(
    parameter int ADDR_W     = 23,
    parameter int DATA_W     = 32,
    parameter int BURST_LEN  = 8,
    parameter int BURST_W    = BURST_W_DEFAULT,
    parameter int FIFO_DEPTH = 16,
    parameter int NBURST_W   = 16
`ifdef FLASH_RD_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = TIMEOUT_DEFAULT
`endif
) (
    input  logic                clk,
    input  logic                RST,
    output logic                flash_mem_read,
    output logic [ADDR_W-1:0]   flash_mem_address,
    output logic [BURST_W-1:0]  flash_mem_burstcount,
    input  logic                flash_mem_waitrequest,
    input  logic [DATA_W-1:0]   flash_mem_readdata,
    input  logic                flash_mem_readdatavalid,
    input  logic                start,
    input  logic [ADDR_W-1:0]   start_addr,
    input  logic [NBURST_W-1:0] num_bursts,
    output logic                busy,
    output logic                error,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_valid,
    input  logic                out_ready
);

    localparam int                 CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BURST_W-1:0] BURST_CNT = BURST_W'(BURST_LEN);

    rd_state_t            state_q, state_d;
    logic [ADDR_W-1:0]    addr_q, addr_d, address_d;
    logic [NBURST_W-1:0]  remaining_q, remaining_d;
    logic [BURST_W-1:0]   beat_q, beat_d, burstcount_d;
    logic                 read_d, busy_d;
    logic [CNT_W-1:0]     fifo_count, fifo_free;
    logic                 fifo_empty, fifo_full;
    logic                 room, push, pop, timeout_hit;

    assign fifo_free = CNT_W'(FIFO_DEPTH) - fifo_count;
    assign room      = !fifo_full && (fifo_free >= CNT_W'(BURST_LEN));
    // Beats outside RECV have no reserved space and are dropped.
    assign push      = flash_mem_readdatavalid && (state_q == RECV);
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;

    flash_rd_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .RST       (RST),
        .push      (push),
        .push_data (flash_mem_readdata),
        .pop       (pop),
        .head      (out_data),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

`ifdef FLASH_RD_TIMEOUT_EN
    logic [15:0] stall_q;
    logic        error_q;
    logic        stalled;

    assign stalled     = ((state_q == REQ) && flash_mem_waitrequest) ||
                         ((state_q == RECV) && !flash_mem_readdatavalid);
    assign timeout_hit = (stall_q > 16'(TIMEOUT_CYC));
    assign error       = error_q;

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            stall_q <= '0;
            error_q <= 1'b0;
        end else begin
            // Any progress (accept, beat) or leaving REQ/RECV clears the count.
            stall_q <= (stalled && !timeout_hit) ? stall_q + 16'd1 : 16'd0;
            if (timeout_hit) begin
                error_q <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign error       = 1'b0;
`endif

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q              <= IDLE;
            addr_q               <= '0;
            remaining_q          <= '0;
            beat_q               <= '0;
            flash_mem_read       <= 1'b0;
            flash_mem_address    <= '0;
            flash_mem_burstcount <= '0;
            busy                 <= 1'b0;
        end else begin
            state_q              <= state_d;
            addr_q               <= addr_d;
            remaining_q          <= remaining_d;
            beat_q               <= beat_d;
            flash_mem_read       <= read_d;
            flash_mem_address    <= address_d;
            flash_mem_burstcount <= burstcount_d;
            busy                 <= busy_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        remaining_d  = remaining_q;
        beat_d       = beat_q;
        read_d       = flash_mem_read;
        address_d    = flash_mem_address;
        burstcount_d = flash_mem_burstcount;
        busy_d       = busy;

        unique case (state_q)
            IDLE: begin
                if (start && !error && (num_bursts != '0)) begin
                    addr_d      = start_addr;
                    remaining_d = num_bursts;
                    busy_d      = 1'b1;
                    // Skip WAIT_ROOM when space is already there so the
                    // first request goes out the cycle after start.
                    if (room) begin
                        read_d       = 1'b1;
                        address_d    = start_addr;
                        burstcount_d = BURST_CNT;
                        state_d      = REQ;
                    end else begin
                        state_d = WAIT_ROOM;
                    end
                end
            end
            WAIT_ROOM: begin
                if (room) begin
                    read_d       = 1'b1;
                    address_d    = addr_q;
                    burstcount_d = BURST_CNT;
                    state_d      = REQ;
                end
            end
            REQ: begin
                if (!flash_mem_waitrequest) begin
                    read_d       = 1'b0;
                    burstcount_d = '0;
                    beat_d       = '0;
                    state_d      = RECV;
                end
            end
            RECV: begin
                if (flash_mem_readdatavalid) begin
                    if (beat_q == BURST_CNT - 1'b1) begin
                        beat_d      = '0;
                        remaining_d = remaining_q - 1'b1;
                        if (remaining_q == NBURST_W'(1)) begin
                            busy_d  = 1'b0;
                            state_d = IDLE;
                        end else begin
                            addr_d  = addr_q + ADDR_W'(BURST_LEN);
                            state_d = WAIT_ROOM;
                        end
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (timeout_hit) begin
            read_d       = 1'b0;
            burstcount_d = '0;
            busy_d       = 1'b0;
            state_d      = IDLE;
        end
    end

endmodule

// File: tb/tb_flash_burst_read_streamer.sv
// Scoreboard bench for flash_burst_read_streamer: a flash slave model answers
// bursts with address-derived data, a monitor checks every popped word and
// every issued command against queues filled when each start is issued.
module tb_flash_burst_read_streamer;

    localparam int ADDR_W     = 23;
    localparam int DATA_W     = 32;
    localparam int BURST_LEN  = 8;
    localparam int BURST_W    = 7;
    localparam int FIFO_DEPTH = 16;
    localparam int NBURST_W   = 16;

    logic                clk = 1'b0;
    logic                RST;
    logic                flash_mem_read;
    logic [ADDR_W-1:0]   flash_mem_address;
    logic [BURST_W-1:0]  flash_mem_burstcount;
    logic                flash_mem_waitrequest;
    logic [DATA_W-1:0]   flash_mem_readdata;
    logic                flash_mem_readdatavalid;
    logic                start;
    logic [ADDR_W-1:0]   start_addr;
    logic [NBURST_W-1:0] num_bursts;
    logic                busy;
    logic                error;
    logic [DATA_W-1:0]   out_data;
    logic                out_valid;
    logic                out_ready;

    always #5 clk = ~clk;

    flash_burst_read_streamer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN),
        .BURST_W(BURST_W), .FIFO_DEPTH(FIFO_DEPTH), .NBURST_W(NBURST_W)
    ) dut (
        .clk                     (clk),
        .RST                     (RST),
        .flash_mem_read          (flash_mem_read),
        .flash_mem_address       (flash_mem_address),
        .flash_mem_burstcount    (flash_mem_burstcount),
        .flash_mem_waitrequest   (flash_mem_waitrequest),
        .flash_mem_readdata      (flash_mem_readdata),
        .flash_mem_readdatavalid (flash_mem_readdatavalid),
        .start                   (start),
        .start_addr              (start_addr),
        .num_bursts              (num_bursts),
        .busy                    (busy),
        .error                   (error),
        .out_data                (out_data),
        .out_valid               (out_valid),
        .out_ready               (out_ready)
    );

    int errors = 0;
    int checks = 0;

    logic [DATA_W-1:0] exp_q[$];
    logic [ADDR_W-1:0] exp_cmd_q[$];
    logic [ADDR_W-1:0] last_cmd_addr = '0;
    int  ncmd = 0;
    int  beats_sent = 0;
    int  wait_left = 0;
    int  read_hi_cycles = 0;
    bit  slave_mute = 1'b0;

    function automatic logic [DATA_W-1:0] model(input logic [ADDR_W-1:0] a);
        return {9'h15A, a};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Flash slave: waitrequest and beats are driven on the falling edge.
    initial begin
        logic [ADDR_W-1:0] addr;
        flash_mem_waitrequest   = 1'b0;
        flash_mem_readdatavalid = 1'b0;
        flash_mem_readdata      = '0;
        forever begin
            @(negedge clk);
            if (!RST && flash_mem_read) begin
                read_hi_cycles++;
                if (exp_cmd_q.size() == 0) begin
                    check("cmd_unexpected", 64'(flash_mem_address), 64'hFFFF_FFFF);
                end else begin
                    check("cmd_addr", 64'(flash_mem_address), 64'(exp_cmd_q[0]));
                end
                check("cmd_burstcount", 64'(flash_mem_burstcount), 64'(BURST_LEN));
                if (wait_left > 0) begin
                    flash_mem_waitrequest = 1'b1;
                    wait_left--;
                end else begin
                    flash_mem_waitrequest = 1'b0;
                    addr = flash_mem_address;
                    last_cmd_addr = addr;
                    if (exp_cmd_q.size() != 0) void'(exp_cmd_q.pop_front());
                    ncmd++;
                    if (!slave_mute) begin
                        @(negedge clk);
                        for (int i = 0; i < BURST_LEN; i++) begin
                            if (RST) break;
                            flash_mem_readdatavalid = 1'b1;
                            flash_mem_readdata      = model(addr + ADDR_W'(i));
                            beats_sent++;
                            @(negedge clk);
                        end
                        flash_mem_readdatavalid = 1'b0;
                    end
                end
            end else begin
                flash_mem_waitrequest = 1'b0;
            end
        end
    end

    // Stream monitor: compare each popped word against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!RST && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("stream_extra", 64'(out_data), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    check("stream_data", 64'(out_data), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic issue(input logic [ADDR_W-1:0] a, input int nb, input bit accept, input bit data);
        logic [ADDR_W-1:0] base;
        @(negedge clk);
        start      = 1'b1;
        start_addr = a;
        num_bursts = NBURST_W'(nb);
        if (accept) begin
            for (int b = 0; b < nb; b++) begin
                base = a + ADDR_W'(b * BURST_LEN);
                exp_cmd_q.push_back(base);
                if (data) begin
                    for (int i = 0; i < BURST_LEN; i++) exp_q.push_back(model(base + ADDR_W'(i)));
                end
            end
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int limit);
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(busy || exp_q.size() != 0), 64'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        RST = 1'b1;
        @(negedge clk);
        check("rst_read", 64'(flash_mem_read), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        exp_q.delete();
        exp_cmd_q.delete();
        @(negedge clk);
        RST = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: got running required finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int n;
        RST        = 1'b1;
        start      = 1'b0;
        start_addr = '0;
        num_bursts = '0;
        out_ready  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_read", 64'(flash_mem_read), 64'd0);
        check("reset_bc", 64'(flash_mem_burstcount), 64'd0);
        check("reset_addr", 64'(flash_mem_address), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_error", 64'(error), 64'd0);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        RST = 1'b0;

        // Reset in the middle of RECV.
        beats_sent = 0;
        issue(23'h000200, 2, 1'b1, 1'b1);
        n = 0;
        while (beats_sent < 3 && n < 50) begin @(negedge clk); n++; end
        check("mid_recv_reached", 64'(beats_sent >= 3), 64'd1);
        pulse_reset();

        // Basic two-burst fetch with free-flowing consumer.
        out_ready  = 1'b1;
        ncmd       = 0;
        beats_sent = 0;
        issue(23'h000100, 2, 1'b1, 1'b1);
        check("latency_read", 64'(flash_mem_read), 64'd1);
        check("latency_addr", 64'(flash_mem_address), 64'h100);
        repeat (5) @(negedge clk);
        issue(23'h000300, 1, 1'b0, 1'b0);
        wait_done("basic_done", 200);
        check("basic_ncmd", 64'(ncmd), 64'd2);
        check("basic_beats", 64'(beats_sent), 64'd16);
        check("basic_last_addr", 64'(last_cmd_addr), 64'h108);

        // num_bursts = 0 is ignored.
        issue(23'h000500, 0, 1'b0, 1'b0);
        check("zero_busy", 64'(busy), 64'd0);
        check("zero_read", 64'(flash_mem_read), 64'd0);

        // waitrequest held for 5 cycles.
        ncmd           = 0;
        read_hi_cycles = 0;
        wait_left      = 5;
        issue(23'h000040, 1, 1'b1, 1'b1);
        wait_done("wait_done", 200);
        check("wait_read_cycles", 64'(read_hi_cycles), 64'd6);
        check("wait_ncmd", 64'(ncmd), 64'd1);

        // Backpressure: third burst waits for space.
        out_ready = 1'b0;
        ncmd      = 0;
        issue(23'h001000, 3, 1'b1, 1'b1);
        repeat (60) @(negedge clk);
        check("bp_ncmd_2", 64'(ncmd), 64'd2);
        check("bp_busy", 64'(busy), 64'd1);
        check("bp_read", 64'(flash_mem_read), 64'd0);
        out_ready = 1'b1;
        repeat (7) @(negedge clk);
        out_ready = 1'b0;
        repeat (6) @(negedge clk);
        check("bp_ncmd_after7", 64'(ncmd), 64'd2);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        repeat (6) @(negedge clk);
        check("bp_ncmd_after8", 64'(ncmd), 64'd3);
        out_ready = 1'b1;
        wait_done("bp_done", 300);

        // Address wrap.
        ncmd = 0;
        issue(23'h7FFFF8, 2, 1'b1, 1'b1);
        wait_done("wrap_done", 200);
        check("wrap_ncmd", 64'(ncmd), 64'd2);
        check("wrap_addr", 64'(last_cmd_addr), 64'h000000);

`ifdef FLASH_RD_TIMEOUT_EN
        slave_mute = 1'b1;
        issue(23'h000020, 1, 1'b1, 1'b0);
        n = 0;
        while (!error && n < 400) begin @(negedge clk); n++; end
        check("to_error", 64'(error), 64'd1);
        check("to_busy", 64'(busy), 64'd0);
        check("to_read", 64'(flash_mem_read), 64'd0);
        slave_mute = 1'b0;
        issue(23'h000060, 1, 1'b0, 1'b0);
        check("to_start_ignored", 64'(busy), 64'd0);
        pulse_reset();
        check("to_error_cleared", 64'(error), 64'd0);
`else
        check("no_timeout_error", 64'(error), 64'd0);
`endif

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
